// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic int cnt_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit combinational full subtractor: d = a - b - bi, with borrow-out.
module fs_cell (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = a ^ b ^ bi;
   assign bo = (~a & b) | (~a & bi) | (b & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor D = A - B, LSB first, through one fs_cell.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bo
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_d;
   logic             r_borrow;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic             w_d;
   logic             w_bo;

   fs_cell u_fs_cell (
      .a  (r_a[0]),
      .b  (r_b[0]),
      .bi (r_borrow),
      .d  (w_d),
      .bo (w_bo)
   );

`ifdef SERIAL_SUB_OVF_EN
   logic r_ovf;
   assign ovf = r_ovf;

   // Overflow is the borrow into the MSB differing from the borrow out of it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (r_state == IDLE && start) begin
         r_ovf <= 1'b0;
      end else if (r_state == SHIFT && r_cnt == LAST) begin
         r_ovf <= r_borrow ^ w_bo;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_d      <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_d      <= '0;
                  r_borrow <= 1'b0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= SHIFT;
               end
            end
            SHIFT: begin
               r_a      <= r_a >> 1;
               r_b      <= r_b >> 1;
               r_d      <= {w_d, r_d[WIDTH-1:1]};
               r_borrow <= w_bo;
               if (r_cnt == LAST) begin
                  r_cnt   <= '0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign d    = r_d;
   assign bo   = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8), directed vectors.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] d;
   logic       bo;
`ifdef SERIAL_SUB_OVF_EN
   logic       ovf;
`endif

   serial_subtractor #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .d     (d),
      .bo    (bo)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  d;
      logic        bo;
      logic        ovf;
      int unsigned cyc;
   } exp_t;

   exp_t        q[$];
   int unsigned cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected result.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected no result", cyc);
         end else begin
            e = q.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("result_d", {24'd0, d}, {24'd0, e.d});
            check("result_bo", {31'd0, bo}, {31'd0, e.bo});
            check("busy_with_done", {31'd0, busy}, 32'd1);
`ifdef SERIAL_SUB_OVF_EN
            check("result_ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
         end
      end
   end

   task automatic issue(input logic [7:0] ta, input logic [7:0] tb, input bit push,
                        input logic [7:0] ed, input logic ebo, input logic eovf,
                        output int unsigned k);
      exp_t e;
      @(negedge clk);
      a = ta;
      b = tb;
      start = 1'b1;
      @(posedge clk);
      #1;
      k = cyc;
      start = 1'b0;
      if (push) begin
         e.d = ed; e.bo = ebo; e.ovf = eovf; e.cyc = k + 8;
         q.push_back(e);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((busy || q.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_chk++;
         n_fail++;
         $display("FAIL idle_timeout: got busy=%0b pending=%0d expected idle", busy, q.size());
         q.delete();
      end
   endtask

   initial begin
      int unsigned k;
      exp_t e;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_d", {24'd0, d}, 32'd0);
      check("reset_bo", {31'd0, bo}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
      rst = 1'b0;

      issue(8'h05, 8'h03, 1'b1, 8'h02, 1'b0, 1'b0, k);
      @(negedge clk);
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      wait_idle();
      check("busy_after_done", {31'd0, busy}, 32'd0);

      issue(8'h03, 8'h05, 1'b1, 8'hFE, 1'b1, 1'b0, k);
      wait_idle();
      repeat (5) @(negedge clk);
      check("hold_d", {24'd0, d}, 32'hFE);
      check("hold_bo", {31'd0, bo}, 32'd1);
      check("hold_done_low", {31'd0, done}, 32'd0);

      issue(8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1, k);
      wait_idle();
      issue(8'h7F, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b1, k);
      wait_idle();

      // Start re-pulsed while cnt=3 must be ignored.
      issue(8'h20, 8'h10, 1'b1, 8'h10, 1'b0, 1'b0, k);
      repeat (3) @(posedge clk);
      @(negedge clk);
      a = 8'h10; b = 8'h01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);

      // Reset in the middle of SHIFT aborts without a done pulse.
      issue(8'h33, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, k);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_d", {24'd0, d}, 32'd0);
      check("abort_bo", {31'd0, bo}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      issue(8'h09, 8'h09, 1'b1, 8'h00, 1'b0, 1'b0, k);
      wait_idle();

      // Start held high: back-to-back operations every WIDTH+2 cycles.
      @(negedge clk);
      a = 8'hAA; b = 8'h55; start = 1'b1;
      @(posedge clk);
      #1;
      k = cyc;
      for (int i = 0; i < 3; i++) begin
         e.d = 8'h55; e.bo = 1'b0; e.ovf = 1'b1; e.cyc = k + 8 + 10 * i;
         q.push_back(e);
      end
      repeat (20) @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (12) @(negedge clk);
      check("scoreboard_empty", q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
